// File: rtl/median_pkg.sv
// Shared types and default constants for the median source actor.
package median_pkg;

  typedef enum logic [1:0] {
    CAPTURE   = 2'd0,
    EMIT_CTRL = 2'd1,
    STREAM    = 2'd2
  } state_t;

  localparam logic [7:0]  DEFAULT_PIVOT_C = 8'd127;
  localparam logic [10:0] BUFF_SIZE_C     = 11'd8;
  localparam logic [9:0]  MEDIAN_POS_C    = 10'd4;

  // Midpoint of the window range; the sum needs 9 bits so 254+255 does not wrap.
  function automatic logic [7:0] pivot_of(input logic [7:0] lo, input logic [7:0] hi);
    logic [8:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[8:1];
  endfunction

endpackage

// File: rtl/median_source_actor_if.sv
// Bundle of the pixel source, pixel sink and the four control-token sinks.
//
// Handshake: every channel is strobe/full (or strobe/empty on the input).
// A token moves on a rising clock edge when the strobe is high; a sink strobe
// is never raised while that sink's full is high, and the data is stable for
// the whole cycle the strobe is high. in_px_rd is only raised while
// in_px_empty is low; the pixel it requests appears on in_px one cycle later.
interface median_source_actor_if #(
  parameter int SIZE_W = 4
);
  logic [7:0]        in_px;
  logic              in_px_rd;
  logic              in_px_empty;

  logic [7:0]        out_px;
  logic              out_px_wr;
  logic              out_px_full;

  logic [7:0]        out_pivot;
  logic              out_pivot_wr;
  logic              out_pivot_full;

  logic [SIZE_W-1:0] out_buff_size;
  logic              out_buff_size_wr;
  logic              out_buff_size_full;

  logic [SIZE_W-1:0] out_median_pos;
  logic              out_median_pos_wr;
  logic              out_median_pos_full;

  logic [7:0]        out_second_median_value;
  logic              out_second_median_value_wr;
  logic              out_second_median_value_full;

  modport master (
    input  in_px, in_px_empty, out_px_full, out_pivot_full, out_buff_size_full,
           out_median_pos_full, out_second_median_value_full,
    output in_px_rd, out_px, out_px_wr, out_pivot, out_pivot_wr, out_buff_size,
           out_buff_size_wr, out_median_pos, out_median_pos_wr,
           out_second_median_value, out_second_median_value_wr
  );

  modport slave (
    output in_px, in_px_empty, out_px_full, out_pivot_full, out_buff_size_full,
           out_median_pos_full, out_second_median_value_full,
    input  in_px_rd, out_px, out_px_wr, out_pivot, out_pivot_wr, out_buff_size,
           out_buff_size_wr, out_median_pos, out_median_pos_wr,
           out_second_median_value, out_second_median_value_wr
  );

endinterface

// File: rtl/median_window_buf.sv
// Window storage: one synchronous write port, one combinational read port so
// the streamed pixel is valid in the same cycle as its write strobe.
module median_window_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Store one captured pixel per write enable.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/median_source_actor.sv
// Captures a window of pixels, emits the control tokens for the median stage
// (pivot, window size, median position, second median value) and then
// replays the window in capture order.
module median_source_actor
  import median_pkg::*;
#(
  parameter logic [9:0]  MEDIAN_POS    = MEDIAN_POS_C,
  parameter logic [10:0] BUFF_SIZE     = BUFF_SIZE_C,
  parameter int          BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
  parameter logic [7:0]  DEFAULT_PIVOT = DEFAULT_PIVOT_C
) (
  input  logic                 clock,
  input  logic                 reset,
  median_source_actor_if.master bus,
  output state_t               dbg_state_o
);

  localparam int SW = BUFF_SIZE_BIT;
  localparam int AW = (BUFF_SIZE > 11'd1) ? $clog2(BUFF_SIZE) : 1;
  localparam logic [SW-1:0] SIZE_TOK = SW'(BUFF_SIZE);
  localparam logic [SW-1:0] MPOS_TOK = SW'(MEDIAN_POS);
  localparam logic [SW-1:0] ONE_S    = SW'(1);
  localparam logic [AW-1:0] ONE_A    = AW'(1);
  localparam logic [AW-1:0] LAST_IDX = AW'(BUFF_SIZE - 11'd1);

  state_t        state_q, state_d;
  logic [SW-1:0] req_cnt_q, req_cnt_d;
  logic          rd_d1_q, rd_d1_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]    min_q, min_d, max_q, max_d;
  logic [7:0]    pivot_q, pivot_d;
  logic [3:0]    done_q, done_d;

  logic          px_rd, px_wr, buf_we;
  logic [3:0]    ctrl_wr, ctrl_full;
  logic [7:0]    min_upd, max_upd, rd_data;

  // Channel order in ctrl_wr/ctrl_full/done: 0 pivot, 1 size, 2 median pos, 3 second value.
  assign ctrl_full = {bus.out_second_median_value_full, bus.out_median_pos_full,
                      bus.out_buff_size_full, bus.out_pivot_full};

  median_window_buf #(.DEPTH(int'(BUFF_SIZE)), .AW(AW)) u_buf (
    .clk_i   (clock),
    .we_i    (buf_we),
    .waddr_i (wr_idx_q),
    .wdata_i (bus.in_px),
    .raddr_i (rd_idx_q),
    .rdata_o (rd_data)
  );

  // State, counters, running min/max, pivot and done flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= CAPTURE;
      req_cnt_q <= '0;
      rd_d1_q   <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      min_q     <= 8'hFF;
      max_q     <= 8'h00;
      pivot_q   <= DEFAULT_PIVOT;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      rd_d1_q   <= rd_d1_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      min_q     <= min_d;
      max_q     <= max_d;
      pivot_q   <= pivot_d;
      done_q    <= done_d;
    end
  end

  // Next-state and strobe logic for capture, control emission and replay.
  always_comb begin
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    rd_d1_d   = 1'b0;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    min_d     = min_q;
    max_d     = max_q;
    pivot_d   = pivot_q;
    done_d    = done_q;
    px_rd     = 1'b0;
    px_wr     = 1'b0;
    buf_we    = 1'b0;
    ctrl_wr   = 4'b0000;
    min_upd   = (bus.in_px < min_q) ? bus.in_px : min_q;
    max_upd   = (bus.in_px > max_q) ? bus.in_px : max_q;
    unique case (state_q)
      CAPTURE: begin
        // Reset gating keeps the read strobe low while reset is held.
        px_rd   = ~reset & ~bus.in_px_empty & (req_cnt_q < SIZE_TOK);
        rd_d1_d = px_rd;
        if (px_rd) req_cnt_d = req_cnt_q + ONE_S;
        // The pixel requested last cycle is on in_px now.
        if (rd_d1_q) begin
          buf_we   = 1'b1;
          min_d    = min_upd;
          max_d    = max_upd;
          wr_idx_d = wr_idx_q + ONE_A;
          if (wr_idx_q == LAST_IDX) begin
            state_d   = EMIT_CTRL;
            pivot_d   = pivot_of(min_upd, max_upd);
            wr_idx_d  = '0;
            req_cnt_d = '0;
          end
        end
      end
      EMIT_CTRL: begin
        ctrl_wr = ~ctrl_full & ~done_q;
        done_d  = done_q | ctrl_wr;
        if (&done_q) begin
          state_d = STREAM;
          done_d  = '0;
        end
      end
      STREAM: begin
        px_wr = ~bus.out_px_full;
        if (px_wr) begin
          rd_idx_d = rd_idx_q + ONE_A;
          if (rd_idx_q == LAST_IDX) begin
            state_d   = CAPTURE;
            rd_idx_d  = '0;
            wr_idx_d  = '0;
            req_cnt_d = '0;
            min_d     = 8'hFF;
            max_d     = 8'h00;
          end
        end
      end
      default: state_d = CAPTURE;
    endcase
  end

  assign bus.in_px_rd                   = px_rd;
  assign bus.out_px_wr                  = px_wr;
  assign bus.out_px                     = (state_q == STREAM) ? rd_data : 8'h00;
  assign bus.out_pivot                  = pivot_q;
  assign bus.out_pivot_wr               = ctrl_wr[0];
  assign bus.out_buff_size              = SIZE_TOK;
  assign bus.out_buff_size_wr           = ctrl_wr[1];
  assign bus.out_median_pos             = MPOS_TOK;
  assign bus.out_median_pos_wr          = ctrl_wr[2];
  assign bus.out_second_median_value    = DEFAULT_PIVOT;
  assign bus.out_second_median_value_wr = ctrl_wr[3];
  assign dbg_state_o                    = state_q;

endmodule
